// File: rtl/fft_seq_pkg.sv
// Shared types and width helpers for the tiny_fft host-side frame sequencer.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYNC,
        CAPTURE,
        DRAIN
    } state_e;

    localparam int unsigned DEF_N_POINTS     = 8;
    localparam int unsigned DEF_SYNC_TIMEOUT = 64;

    // Bin index width.
    function automatic int unsigned idx_w(input int unsigned n_points);
        return $clog2(n_points);
    endfunction

    // Word/sample counters carry one spare bit beyond the 2N word address.
    function automatic int unsigned word_idx_w(input int unsigned n_points);
        return $clog2(2 * n_points) + 1;
    endfunction

    function automatic int unsigned sync_cnt_w(input int unsigned timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/fft_bin_buffer.sv
// Capture buffer for one FFT frame: 2*N words, real at even and imag at odd addresses.
module fft_bin_buffer #(
    parameter int unsigned N_POINTS = 8,
    parameter int unsigned DOUT_W   = 6,
    localparam int unsigned ADDR_W  = $clog2(2 * N_POINTS),
    localparam int unsigned BIN_W   = $clog2(N_POINTS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] widx_i,
    input  logic [DOUT_W-1:0] wdata_i,
    input  logic [BIN_W-1:0]  rbin_i,
    output logic [DOUT_W-1:0] rreal_o,
    output logic [DOUT_W-1:0] rimag_o
);

    logic [DOUT_W-1:0] mem_q [2*N_POINTS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rreal_o = mem_q[{rbin_i, 1'b0}];
    assign rimag_o = mem_q[{rbin_i, 1'b1}];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Loads one frame into tiny_fft, locks onto its free-running output at bin 0,
// captures a full frame and replays it over a stallable valid/ready stream.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned N_POINTS     = DEF_N_POINTS,
    parameter int unsigned DIN_W        = 4,
    parameter int unsigned DOUT_W       = 6,
    parameter int unsigned SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DIN_W-1:0]             s_data,
    output logic                         fft_wr_en,
    output logic [DIN_W-1:0]             fft_data_in,
    input  logic [DOUT_W-1:0]            fft_data_out,
    input  logic                         fft_real,
    input  logic                         fft_rd_idx_zero,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [idx_w(N_POINTS)-1:0]   m_bin,
    output logic [DOUT_W-1:0]            m_real,
    output logic [DOUT_W-1:0]            m_imag,
    output logic                         m_last,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err
);

    localparam int unsigned BIN_W  = idx_w(N_POINTS);
    localparam int unsigned WIDX_W = word_idx_w(N_POINTS);
    localparam int unsigned SCNT_W = sync_cnt_w(SYNC_TIMEOUT);

    localparam logic [WIDX_W-1:0] LAST_SAMPLE = WIDX_W'(N_POINTS - 1);
    localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(2 * N_POINTS - 1);
    localparam logic [BIN_W-1:0]  LAST_BIN    = BIN_W'(N_POINTS - 1);
    localparam logic [SCNT_W-1:0] LAST_SYNC   = SCNT_W'(SYNC_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WIDX_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [SCNT_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [WIDX_W-1:0]   word_q, word_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [DIN_W-1:0]    din_q, din_d;
    logic                done_q, done_d;

    logic                buf_we;
    logic [WIDX_W-2:0]   buf_widx;
    logic [DOUT_W-1:0]   rd_real, rd_imag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            smp_cnt_q  <= '0;
            sync_cnt_q <= '0;
            word_q     <= '0;
            bin_q      <= '0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            word_q     <= word_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        sync_cnt_d = sync_cnt_q;
        word_d     = word_q;
        bin_d      = bin_q;
        err_d      = err_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        buf_we     = 1'b0;
        buf_widx   = '0;

        // Abort pre-empts every handshake and start; err is left alone.
        if (abort) begin
            state_d = IDLE;
            bin_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = LOAD;
                        err_d     = 1'b0;
                        smp_cnt_d = '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        din_d     = s_data;
                        wr_en_d   = 1'b1;
                        smp_cnt_d = smp_cnt_q + 1'b1;
                        if (smp_cnt_q == LAST_SAMPLE) begin
                            state_d    = SYNC;
                            sync_cnt_d = '0;
                        end
                    end
                end
                SYNC: begin
                    if (fft_rd_idx_zero && fft_real) begin
                        buf_we  = 1'b1;
                        word_d  = WIDX_W'(1);
                        state_d = CAPTURE;
                    end else if (sync_cnt_q == LAST_SYNC) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    // Even word index must carry the real flag, odd must not.
                    if (fft_real != !word_q[0]) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        buf_we   = 1'b1;
                        buf_widx = word_q[WIDX_W-2:0];
                        if (word_q == LAST_WORD) begin
                            state_d = DRAIN;
                            bin_d   = '0;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (bin_q == LAST_BIN) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            bin_d   = '0;
                        end else begin
                            bin_d = bin_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    fft_bin_buffer #(
        .N_POINTS (N_POINTS),
        .DOUT_W   (DOUT_W)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .widx_i  (buf_widx),
        .wdata_i (fft_data_out),
        .rbin_i  (bin_q),
        .rreal_o (rd_real),
        .rimag_o (rd_imag)
    );

    // Data outputs are gated so they read zero outside DRAIN, including under reset.
    assign m_valid     = (state_q == DRAIN);
    assign m_real      = m_valid ? rd_real : '0;
    assign m_imag      = m_valid ? rd_imag : '0;
    assign m_bin       = bin_q;
    assign m_last      = m_valid && (bin_q == LAST_BIN);
    assign s_ready     = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign fft_wr_en   = wr_en_q;
    assign fft_data_in = din_q;
    assign frame_done  = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer against a stationary cyclic tiny_fft output model.
module tb_fft_frame_sequencer;

    localparam int N    = 8;
    localparam int DIN  = 4;
    localparam int DOUT = 6;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst, start, abort, s_valid, m_ready;
    logic [DIN-1:0]  s_data;
    logic            s_ready, fft_wr_en, fft_real, fft_rd_idx_zero;
    logic [DIN-1:0]  fft_data_in;
    logic [DOUT-1:0] fft_data_out;
    logic            m_valid, m_last, busy, frame_done, err;
    logic [DOUT-1:0] m_real, m_imag;
    logic [2:0]      m_bin;

    int n_checks = 0;
    int n_errors = 0;

    // Core output model: frame words repeat with period 2N; word w is real when even, bin 0 when w<2.
    logic [DOUT-1:0] words [2*N];
    int unsigned     core_ph;
    int              core_mode = 0;  // 0 normal, 1 never flags bin 0, 2 real flag stuck on word 3

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .N_POINTS     (N),
        .DIN_W        (DIN),
        .DOUT_W       (DOUT),
        .SYNC_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .fft_wr_en       (fft_wr_en),
        .fft_data_in     (fft_data_in),
        .fft_data_out    (fft_data_out),
        .fft_real        (fft_real),
        .fft_rd_idx_zero (fft_rd_idx_zero),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_bin           (m_bin),
        .m_real          (m_real),
        .m_imag          (m_imag),
        .m_last          (m_last),
        .busy            (busy),
        .frame_done      (frame_done),
        .err             (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        fft_data_out    = '0;
        fft_real        = 1'b0;
        fft_rd_idx_zero = 1'b0;
        core_ph         = $urandom_range(0, 2*N-1);
        forever begin
            @(negedge clk);
            begin
                int unsigned w;
                w = core_ph % (2*N);
                fft_data_out    = words[w];
                fft_real        = (w % 2 == 0) || (core_mode == 2 && w == 3);
                fft_rd_idx_zero = (core_mode != 1) && (w < 2);
                core_ph++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic new_words(input bit fixed_bin0);
        for (int i = 0; i < 2*N; i++) words[i] = DOUT'($urandom);
        if (fixed_bin0) begin
            words[0] = 6'h05;
            words[1] = 6'h3A;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_err_clr", err, 0);
        check_eq("start_s_ready", s_ready, 1);
    endtask

    task automatic load_frame(input bit hold_valid, input bit seq_data);
        int sent = 0;
        int guard = 0;
        bit pend = 0;
        logic [DIN-1:0] pdata = '0;
        while ((sent < N || pend) && guard < 200) begin
            check_eq("wr_en", fft_wr_en, pend);
            if (pend) check_eq("wr_data", fft_data_in, pdata);
            check_eq("s_ready", s_ready, sent < N);
            s_valid = hold_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            s_data  = seq_data ? DIN'(sent + 1) : DIN'($urandom);
            start   = (sent < N) && ($urandom_range(0, 7) == 0);
            pend    = s_valid && (sent < N);
            pdata   = s_data;
            if (pend) sent++;
            guard++;
            step();
        end
        check_eq("load_count", sent, N);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic drain_frame(input int rdy_mode);
        int idx = 0;
        int cyc = 0;
        int guard = 0;
        int early_done = 0;
        int unsigned pat [4] = '{1, 0, 0, 1};
        while (idx < N && guard < 400) begin
            if (frame_done) early_done++;
            if (m_valid) begin
                check_eq("m_bin", m_bin, idx);
                check_eq("m_real", m_real, words[2*idx]);
                check_eq("m_imag", m_imag, words[2*idx+1]);
                check_eq("m_last", m_last, idx == N-1);
            end
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[cyc % 4] != 0;
                default: m_ready = $urandom_range(0, 1) != 0;
            endcase
            if (m_valid) cyc++;
            if (m_valid && m_ready) idx++;
            guard++;
            step();
        end
        check_eq("drain_beats", idx, N);
        check_eq("early_done", early_done, 0);
        check_eq("frame_done", frame_done, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_m_valid", m_valid, 0);
        m_ready = 1'b0;
        step();
        check_eq("done_pulse_end", frame_done, 0);
        check_eq("err_after_frame", err, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        new_words(1'b1);
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_wr_en", fft_wr_en, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_m_data", {m_real, m_imag, m_bin, m_last}, 0);
        step();
        rst = 1'b0;
        step();
        check_eq("idle_s_ready", s_ready, 0);

        // Sequential samples 1..N, free-flowing drain, then stall pattern and random stalls.
        do_start();
        load_frame(1'b1, 1'b1);
        drain_frame(0);
        for (int f = 0; f < 3; f++) begin
            new_words(1'b0);
            do_start();
            load_frame(1'b0, 1'b0);
            drain_frame(f == 0 ? 1 : 2);
        end

        // Bin 0 never flagged: timeout exactly TMO cycles after SYNC entry.
        core_mode = 1;
        do_start();
        load_frame(1'b1, 1'b0);
        for (int i = 0; i < TMO - 2; i++) step();
        check_eq("tmo_pre_busy", busy, 1);
        check_eq("tmo_pre_err", err, 0);
        step();
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_err", err, 1);
        core_mode = 0;

        // Restart clears err; abort after three samples kills the frame.
        do_start();
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = DIN'(i + 9);
            step();
        end
        check_eq("abort_prev_wr", fft_wr_en, 1);
        check_eq("abort_prev_data", fft_data_in, 11);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_s_ready", s_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_wr_en", fft_wr_en, 0);
            step();
        end
        s_valid = 1'b0;
        check_eq("abort_err", err, 0);

        // Real flag asserted on word 3: error, no output beats.
        core_mode = 2;
        new_words(1'b0);
        do_start();
        load_frame(1'b0, 1'b0);
        begin
            int guard = 0;
            int saw_mv = 0;
            m_ready = 1'b1;
            while (busy && guard < 200) begin
                if (m_valid) saw_mv++;
                guard++;
                step();
            end
            check_eq("misalign_idle", busy, 0);
            check_eq("misalign_err", err, 1);
            check_eq("misalign_m_valid", saw_mv, 0);
            m_ready = 1'b0;
        end
        core_mode = 0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_keeps_err", err, 1);

        // Asynchronous reset in the middle of DRAIN.
        new_words(1'b0);
        do_start();
        load_frame(1'b0, 1'b0);
        begin
            int guard = 0;
            while (!m_valid && guard < 200) begin
                guard++;
                step();
            end
            check_eq("reach_drain", m_valid, 1);
        end
        m_ready = 1'b1;
        step(); step(); step();
        m_ready = 1'b0;
        check_eq("mid_drain_bin", m_bin, 3);
        check_eq("mid_drain_real", m_real, words[6]);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_m_valid", m_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_m_data", {m_real, m_imag, m_bin, m_last}, 0);
        check_eq("arst_misc", {s_ready, fft_wr_en, fft_data_in, frame_done, err}, 0);
        step();
        rst = 1'b0;
        step();

        new_words(1'b0);
        do_start();
        load_frame(1'b0, 1'b0);
        drain_frame(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Host-side controller for the tiny_fft core.
- Accepts a stream of 4-bit samples and writes exactly one N-point frame into the core via its write strobe and data lines.
- Then synchronises to the core's output sequence, using the bin-zero marker and the real/imag flag, and captures one full frame of real/imag pairs.
- Replays the captured bins downstream over a valid/ready stream, so consumers can stall even though the core's output is free-running.

Parameters:
- N_POINTS, 8, FFT frame length in samples/bins (power of 2, ≥2)
- DIN_W, 4, sample width driven to the core
- DOUT_W, 6, core output word width
- SYNC_TIMEOUT, 64, max cycles spent waiting for the bin-0 real word before flagging an error

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to process one frame
- abort  in  1  synchronous abort, returns to IDLE
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream sample ready
- s_data  in  DIN_W  upstream sample
- fft_wr_en  out  1  write strobe to core
- fft_data_in  out  DIN_W  sample to core
- fft_data_out  in  DOUT_W  core output word
- fft_real  in  1  core flag: current word is real part
- fft_rd_idx_zero  in  1  core flag: current word belongs to bin 0
- m_valid  out  1  downstream bin valid
- m_ready  in  1  downstream bin ready
- m_real  out  DOUT_W  bin real part
- m_imag  out  DOUT_W  bin imaginary part
- m_bin  out  $clog2(N_POINTS)  bin index
- m_last  out  1  final bin of frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after last bin is accepted
- err  out  1  sticky error (timeout or real/imag misalignment); cleared by start

Behaviour:
- Reset (async) values:
  - state=IDLE; all outputs 0; counters 0; err=0.
  - Buffer contents don't-care.
- IDLE:
  - s_ready=0.
  - start=1 → LOAD next cycle; clears err and the sample counter.
- LOAD:
  - s_ready=1.
  - Each s_valid&s_ready handshake registers s_data into fft_data_in and pulses fft_wr_en=1 on the following cycle (latency 1). fft_wr_en=0 in every other cycle.
  - After the N_POINTS-th handshake → SYNC. That handshake's wr_en pulse still issues in the first SYNC cycle.
  - No other sample is accepted after that handshake (s_ready=0 from SYNC onward).
- SYNC:
  - Timeout counter increments each cycle.
  - Cycle with fft_rd_idx_zero=1 & fft_real=1 → that word is stored as bin0.real; go to CAPTURE with word index 1.
  - Counter reaching SYNC_TIMEOUT with no match → err=1, return to IDLE.
- CAPTURE:
  - One word per cycle, word index k = 1..2N-1.
  - Even k → real of bin k/2; odd k → imag of bin k/2.
  - Required fft_real = (k even). Any mismatch → err=1, go to IDLE, discard the frame.
  - After k=2N-1 is stored → DRAIN with bin index 0.
- DRAIN:
  - m_valid=1; m_real/m_imag come from the buffer at m_bin; m_last=(m_bin==N-1).
  - Outputs hold stable while m_valid&!m_ready.
  - On handshake, m_bin increments. Last handshake → IDLE, with frame_done=1 in the same cycle as IDLE entry.
- Ignored inputs:
  - start outside IDLE is ignored, with no effect on state or err.
  - s_valid outside LOAD is ignored.
- abort:
  - Valid in any state; next cycle state=IDLE, fft_wr_en=0, m_valid=0.
  - err unchanged.
  - abort wins over start and over any simultaneous handshake; the handshake is not counted.
- Index wrap: counters are sized $clog2(2N)+1. No wrap-around occurs within a frame.
- Width rules: no arithmetic on data; buffer word = DOUT_W bits, stored verbatim.

Decomposition:
- Package fft_seq_pkg:
  - state enum {IDLE, LOAD, SYNC, CAPTURE, DRAIN}
  - IDX_W = $clog2(N_POINTS)
  - WORD_IDX_W
  - SYNC_CNT_W
- Sub-module fft_bin_buffer:
  - 2·N_POINTS × DOUT_W register file.
  - Single write port (word index, data, we).
  - Combinational dual read of the real/imag pair for a given bin.

Test Plan:
- start; feed samples 1..8 with s_valid held high → exactly 8 fft_wr_en pulses, fft_data_in=1..8, each one cycle after its handshake; s_ready=0 after the 8th handshake.
- Core model emits bin0 real=0x05 (rd_idx_zero=1, real=1), imag=0x3A, then alternating words for bins 1..7; m_ready=1 → 8 beats, bin0 = {m_real=0x05, m_imag=0x3A}, m_last only on bin 7, frame_done pulses once, busy=0 afterwards.
- m_ready toggled 1-0-0-1 during DRAIN → m_real/m_imag/m_bin hold while stalled; all 8 bins delivered in order with no duplicates.
- Core never asserts rd_idx_zero → err=1 and IDLE exactly SYNC_TIMEOUT(64) cycles after SYNC entry; the next start clears err.
- fft_real=1 on word index 3 during CAPTURE → err=1, IDLE, no m_valid; abort asserted mid-LOAD after 3 samples → IDLE next cycle, no further fft_wr_en; rst asserted mid-DRAIN → all outputs 0 immediately (asynchronously).
